calc_key_entry: RTL and testbench

Sequential front end that drives the combinational 4-bit calculator's operand and function inputs from a stream of keystroke codes. It assembles operand A, an operator and operand B, then holds ain/bin/fun stable for a fixed settle window. It captures the calculator's 8-bit result into a registered output with a one-cycle valid pulse. It also flags divide-by-zero and supports chaining the previous result into the next operation.

---
 rtl/calc_key_entry.sv | 121 ++++++++++++
 tb/tb_calc_key_entry.sv | 128 ++++++++++++
 2 files changed

// File: rtl/calc_key_entry.sv
// calc_key_entry: keystroke front end that sequences operands/operator into a 4-bit calculator and captures its result
module calc_key_entry #(
   parameter int EXEC_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [4:0] key_code,
   output logic [3:0] ain,
   output logic [3:0] bin,
   output logic [2:0] fun,
   input  logic [7:0] res_in,
   output logic [7:0] result,
   output logic       result_valid,
   output logic       err,
   output logic       busy,
   output logic [2:0] state_dbg
);
   typedef enum logic [2:0] {GET_A = 3'd0, GET_OP = 3'd1, GET_B = 3'd2, EXEC = 3'd3, DONE = 3'd4} state_t;
   state_t state, state_n;
   logic [3:0] ain_n, bin_n, cnt, cnt_n;
   logic [2:0] fun_n;
   logic [7:0] result_n;
   logic       result_valid_n, err_n, b_set, b_set_n;
   logic       is_dig, is_op, is_eq, is_clr;
   assign is_dig    = key_valid && !key_code[4];
   assign is_op     = key_valid && key_code[4:2] == 3'b100;
   assign is_eq     = key_valid && key_code == 5'h14;
   assign is_clr    = key_valid && key_code == 5'h15;
   assign busy      = state == EXEC;
   assign state_dbg = state;
   always_comb begin
      state_n        = state;
      ain_n          = ain;
      bin_n          = bin;
      fun_n          = fun;
      result_n       = result;
      result_valid_n = 1'b0;
      err_n          = err;
      cnt_n          = cnt;
      b_set_n        = b_set;
      if (is_clr && state != EXEC) begin
         state_n = GET_A;
         ain_n   = '0;
         bin_n   = '0;
         fun_n   = '0;
         err_n   = 1'b0;
         cnt_n   = '0;
         b_set_n = 1'b0;
      end else begin
         case (state)
            GET_A: if (is_dig) begin
               ain_n   = key_code[3:0];
               state_n = GET_OP;
            end
            GET_OP: if (is_dig) ain_n = key_code[3:0];
               else if (is_op) begin
                  fun_n   = {1'b0, key_code[1:0]};
                  b_set_n = 1'b0;
                  state_n = GET_B;
               end
            GET_B: if (is_dig) begin
                  bin_n   = key_code[3:0];
                  b_set_n = 1'b1;
               end else if (is_op) fun_n = {1'b0, key_code[1:0]};
               else if (is_eq && b_set) begin
                  cnt_n   = '0;
                  state_n = EXEC;
               end
            EXEC: begin
               cnt_n = cnt + 4'd1;
               if (cnt == 4'(EXEC_CYCLES - 1)) begin
                  state_n        = DONE;
                  result_valid_n = 1'b1;
                  result_n       = (fun == 3'b011 && bin == 4'd0) ? 8'hFF : res_in;
                  err_n          = err | (fun == 3'b011 && bin == 4'd0);
               end
            end
            DONE: if (is_dig) begin
                  ain_n   = key_code[3:0];
                  bin_n   = '0;
                  state_n = GET_OP;
               end else if (is_op) begin
                  // chaining keeps only the low nibble of the previous result
                  ain_n   = result[3:0];
                  bin_n   = '0;
                  fun_n   = {1'b0, key_code[1:0]};
                  b_set_n = 1'b0;
                  state_n = GET_B;
               end else if (is_eq) begin
                  cnt_n   = '0;
                  state_n = EXEC;
               end
            default: state_n = GET_A;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= GET_A;
         ain          <= '0;
         bin          <= '0;
         fun          <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         err          <= 1'b0;
         cnt          <= '0;
         b_set        <= 1'b0;
      end else begin
         state        <= state_n;
         ain          <= ain_n;
         bin          <= bin_n;
         fun          <= fun_n;
         result       <= result_n;
         result_valid <= result_valid_n;
         err          <= err_n;
         cnt          <= cnt_n;
         b_set        <= b_set_n;
      end
   end
endmodule

// File: tb/tb_calc_key_entry.sv
// tb_calc_key_entry: directed keystroke sequences with hand-computed expectations
module tb_calc_key_entry;
   localparam int EC = 2;
   localparam logic [4:0] ADD = 5'h10, SUB = 5'h11, MUL = 5'h12, DIV = 5'h13, EQ = 5'h14, CLR = 5'h15;
   logic clk = 0, rst = 1, key_valid = 0;
   logic [4:0] key_code = '0;
   logic [3:0] ain, bin;
   logic [2:0] fun, state_dbg;
   logic [7:0] res_in, result;
   logic result_valid, err, busy;
   int checks = 0, errors = 0;
   calc_key_entry #(.EXEC_CYCLES(EC)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .ain(ain), .bin(bin), .fun(fun), .res_in(res_in), .result(result),
      .result_valid(result_valid), .err(err), .busy(busy), .state_dbg(state_dbg)
   );
   always #5 clk = ~clk;
   // calculator stand-in; divide by zero deliberately yields 0 so the DUT override is visible
   always_comb begin
      res_in = 8'h00;
      case (fun)
         3'b000: res_in = 8'(ain) + 8'(bin);
         3'b001: res_in = 8'(ain) - 8'(bin);
         3'b010: res_in = 8'(ain) * 8'(bin);
         3'b011: res_in = (bin == 0) ? 8'h00 : 8'(ain / bin);
         default: res_in = 8'h00;
      endcase
   end
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   task automatic press(input logic [4:0] c);
      key_valid = 1;
      key_code  = c;
      @(negedge clk);
      key_valid = 0;
   endtask
   task automatic run_eq(input string tag, input logic [7:0] exp);
      int n = 0;
      press(EQ);
      chk({tag, "_busy"}, 8'(busy), 8'd1);
      while (!result_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 8'(n), 8'(EC));
      chk({tag, "_res"}, result, exp);
      @(negedge clk);
      chk({tag, "_pulse"}, 8'(result_valid), 8'd0);
   endtask
   initial begin
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      chk("rst_state", 8'(state_dbg), 8'd0);
      chk("rst_ain", 8'(ain), 8'd0);
      chk("rst_bin", 8'(bin), 8'd0);
      chk("rst_fun", 8'(fun), 8'd0);
      chk("rst_res", result, 8'd0);
      chk("rst_flags", {4'd0, result_valid, err, busy, 1'b0}, 8'd0);
      press(5'h1F);
      chk("undef_state", 8'(state_dbg), 8'd0);
      key_code = 5'h6;
      @(negedge clk);
      chk("nokv_state", 8'(state_dbg), 8'd0);
      press(5'h6); press(ADD); press(5'h3);
      chk("add_ops", {ain, bin}, 8'h63);
      chk("add_fun", 8'(fun), 8'd0);
      run_eq("add", 8'h09);
      chk("add_err", 8'(err), 8'd0);
      press(5'h3); press(SUB); press(5'h6);
      chk("sub_fun", 8'(fun), 8'd1);
      run_eq("sub", 8'hFD);
      press(MUL); press(5'h2);
      chk("chain_ops", {ain, bin}, 8'hD2);
      chk("chain_fun", 8'(fun), 8'd2);
      run_eq("chain", 8'h1A);
      press(5'hF); press(MUL); press(5'hF);
      run_eq("mul", 8'hE1);
      run_eq("rerun", 8'hE1);
      press(5'h9); press(DIV); press(5'h0);
      run_eq("div0", 8'hFF);
      chk("div0_err", 8'(err), 8'd1);
      press(5'h8); press(DIV); press(5'h2);
      run_eq("div", 8'h04);
      chk("div_err", 8'(err), 8'd1);
      press(CLR);
      chk("clr_err", 8'(err), 8'd0);
      chk("clr_state", 8'(state_dbg), 8'd0);
      chk("clr_res", result, 8'h04);
      press(5'h5); press(ADD); press(EQ);
      chk("nob_state", 8'(state_dbg), 8'd2);
      chk("nob_rv", 8'(result_valid), 8'd0);
      press(5'h1); press(5'h2);
      chk("nob_bin", 8'(bin), 8'd2);
      run_eq("nob", 8'h07);
      press(5'h3); press(ADD); press(5'h4);
      key_valid = 1; key_code = EQ;
      @(negedge clk);
      key_code = 5'h9;
      @(negedge clk);
      key_code = CLR;
      @(negedge clk);
      key_valid = 0;
      chk("busy_rv", 8'(result_valid), 8'd1);
      chk("busy_res", result, 8'h07);
      chk("busy_ops", {ain, bin}, 8'h34);
      chk("busy_state", 8'(state_dbg), 8'd4);
      press(5'h1); press(ADD); press(5'h1); press(EQ);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("mrst_state", 8'(state_dbg), 8'd0);
      chk("mrst_res", result, 8'd0);
      chk("mrst_ops", {ain, bin}, 8'd0);
      chk("mrst_flags", {4'd0, result_valid, err, busy, 1'b0}, 8'd0);
      repeat (4) begin
         @(negedge clk);
         chk("mrst_nopulse", 8'(result_valid), 8'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
